// File: rtl/mmio_stream_fifo_if.sv
// rtl/mmio_stream_fifo_if.sv - processor bus and output stream bundle for mmio_stream_fifo
interface mmio_stream_fifo_if;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic [15:0] rd_data;
  logic        rd_hit;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output ADDR, DOUT, W, out_ready,
    input  rd_data, rd_hit, out_data, out_valid
  );

  modport slave (
    input  ADDR, DOUT, W, out_ready,
    output rd_data, rd_hit, out_data, out_valid
  );
endinterface

// File: rtl/mmio_stream_fifo.sv
// rtl/mmio_stream_fifo.sv - memory-mapped store capture FIFO drained over a valid/ready stream
module mmio_stream_fifo #(
  parameter logic [3:0] BASE  = 4'h3,
  parameter int         DEPTH = 8,
  parameter int         AW    = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  mmio_stream_fifo_if.slave  bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          drain_en_q, drain_en_d;
  logic [15:0]   drops_q, drops_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_hit_q, rd_hit_d;

  logic          hit;
  logic [1:0]    off;
  logic          wr_en, push_req, ctrl_wr, drops_wr, flush;
  logic          full, empty, pop, do_push, overflow;
  logic [15:0]   head, sel;
  logic [7:0]    count_lo;
  logic          unused_addr;

  // ADDR[11:2] do not decode, so the four registers alias across the window.
  assign unused_addr = ^bus.ADDR[11:2];

  assign hit      = (bus.ADDR[15:12] == BASE);
  assign off      = bus.ADDR[1:0];
  assign wr_en    = bus.W & hit;
  assign push_req = wr_en & (off == 2'd0);
  assign ctrl_wr  = wr_en & (off == 2'd2);
  assign drops_wr = wr_en & (off == 2'd3);
  assign flush    = ctrl_wr & bus.DOUT[0];

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign count_lo = 8'(count_q);

  assign bus.out_valid = drain_en_q & ~empty;
  assign bus.out_data  = head;

  // Fullness is judged before the edge, so a same-edge pop never frees a slot for the push.
  assign pop      = bus.out_valid & bus.out_ready & ~flush;
  assign do_push  = push_req & ~full & ~flush;
  assign overflow = push_req & full;

  always_comb begin
    sel = 16'h0000;
    case (off)
      2'd0:    sel = empty ? 16'h0000 : head;
      2'd1:    sel = {full, empty, 6'b0, count_lo};
      2'd2:    sel = {14'b0, drain_en_q, 1'b0};
      default: sel = drops_q;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drain_en_d = drain_en_q;
    drops_d    = drops_q;
    rd_hit_d   = hit;
    rd_data_d  = hit ? sel : 16'h0000;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
    end

    if (ctrl_wr) drain_en_d = bus.DOUT[1];

    if (drops_wr) begin
      drops_d = 16'h0000;
    end else if (overflow && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drain_en_q <= 1'b1;
      drops_q    <= 16'h0000;
      rd_data_q  <= 16'h0000;
      rd_hit_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drain_en_q <= drain_en_d;
      drops_q    <= drops_d;
      rd_data_q  <= rd_data_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= bus.DOUT;
  end

  assign bus.rd_data = rd_data_q;
  assign bus.rd_hit  = rd_hit_q;

endmodule
